// File: rtl/dp_arb_pkg.sv
// Shared types for the port-B data arbiter: master IDs, lock FSM states and
// the read-response tag that travels alongside each RAM read.
package dp_arb_pkg;

  typedef enum logic {
    MID_M0 = 1'b0,
    MID_M1 = 1'b1
  } mid_e;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic valid;
    mid_e id;
  } rd_tag_t;

  // The master that is not m; used for round-robin tie breaking.
  function automatic mid_e other_mid(input mid_e m);
    return (m == MID_M0) ? MID_M1 : MID_M0;
  endfunction

endpackage

// File: rtl/rsp_tag_pipe.sv
// Shift register of read tags matching the RAM read latency. A tag pushed on
// an accepted read emerges at the tail exactly when the RAM data is valid.
module rsp_tag_pipe
  import dp_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t push_tag,
  output rd_tag_t tail_tag
);

  rd_tag_t stage_q [DEPTH];

  // Advance every stage each cycle; reset drops all in-flight responses.
  // NOTE: the tag stages carry valid bits, so unlike a data-only delay line
  // they must be reset, otherwise stale tags would fire rvalid after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '{valid: 1'b0, id: MID_M0};
      end
    end else begin
      stage_q[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tail_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/data_port_arbiter.sv
// Shares RAM port B between M0 (core load/store) and M1 (DMA/boot loader).
// Round-robin arbitration with an optional bounded master lock; each read is
// tagged so its data is returned to the master that issued it.
module data_port_arbiter
  import dp_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state_q, state_d;
  mid_e             last_q, last_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  logic             arb_valid;
  mid_e             arb_id;
  logic             gnt_any;
  logic             win_lock;
  logic             lock_hold;
  logic [CNT_W-1:0] cnt_inc;

  rd_tag_t          push_tag;
  rd_tag_t          tail_tag;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  // Pick this cycle's winner: a requesting lock owner first, otherwise
  // single requester, otherwise the master that did not win last.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    arb_valid = 1'b0;
    arb_id    = MID_M0;
    lock_hold = 1'b0;
    if (state_q == ST_LOCK0 && m0_req) begin
      arb_valid = 1'b1;
      arb_id    = MID_M0;
      lock_hold = 1'b1;
    end else if (state_q == ST_LOCK1 && m1_req) begin
      arb_valid = 1'b1;
      arb_id    = MID_M1;
      lock_hold = 1'b1;
    end else if (m0_req && m1_req) begin
      arb_valid = 1'b1;
      arb_id    = other_mid(last_q);
    end else if (m0_req) begin
      arb_valid = 1'b1;
      arb_id    = MID_M0;
    end else if (m1_req) begin
      arb_valid = 1'b1;
      arb_id    = MID_M1;
    end
  end

  // No grant may be issued while reset is held.
  assign gnt_any  = arb_valid && !reset;
  assign m0_gnt   = gnt_any && (arb_id == MID_M0);
  assign m1_gnt   = gnt_any && (arb_id == MID_M1);
  assign win_lock = (arb_id == MID_M0) ? m0_lock : m1_lock;
  assign cnt_inc  = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CNT_ONE;

  // Lock owner FSM, lock counter and round-robin history.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    if (arb_valid) begin
      last_d = arb_id;
    end
    if (lock_hold) begin
      // Owner transfers: keep the lock unless released or the budget runs out.
      lock_cnt_d = cnt_inc;
      if (!win_lock || cnt_inc == CNT_MAX) begin
        state_d = ST_FREE;
      end
    end else if (arb_valid && win_lock) begin
      // Locking transfer from the free state (or after the owner dropped req).
      lock_cnt_d = CNT_ONE;
      if (MAX_LOCK > 1) begin
        state_d = (arb_id == MID_M0) ? ST_LOCK0 : ST_LOCK1;
      end else begin
        state_d = ST_FREE;
      end
    end else begin
      state_d    = ST_FREE;
      lock_cnt_d = '0;
    end
  end

  // Arbiter state registers.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FREE;
      last_q     <= MID_M1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Forward the granted master's request to RAM port B; idle bus is all zero.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_any) begin
      mem_en = 1'b1;
      if (arb_id == MID_M0) begin
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
      end else begin
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end
    end
  end

  assign push_tag = '{valid: gnt_any && !mem_we, id: arb_id};

  rsp_tag_pipe #(
    .DEPTH (READ_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .push_tag (push_tag),
    .tail_tag (tail_tag)
  );

  assign m0_rvalid = tail_tag.valid && (tail_tag.id == MID_M0);
  assign m1_rvalid = tail_tag.valid && (tail_tag.id == MID_M1);

  // Remember the last returned word per master so rdata holds between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      if (m0_rvalid) m0_rdata_q <= mem_rdata;
      if (m1_rvalid) m1_rdata_q <= mem_rdata;
    end
  end

  assign m0_rdata = m0_rvalid ? mem_rdata : m0_rdata_q;
  assign m1_rdata = m1_rvalid ? mem_rdata : m1_rdata_q;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed bench for data_port_arbiter with a behavioural port-B RAM model.
module tb_data_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int READ_LAT = 2;
  localparam int MAX_LOCK = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  data_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_lock   (m0_lock),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM port B model: word index addr[12:2], READ_LAT-cycle read pipeline.
  logic [DATA_W-1:0] ram [2048];
  logic [DATA_W-1:0] rd_pipe [READ_LAT];

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < READ_LAT; i++) rd_pipe[i] = '0;
  end

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr[12:2]] <= mem_wdata;
    if (mem_en && !mem_we) rd_pipe[0] <= ram[mem_addr[12:2]];
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[READ_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drive1(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle();
    next_cycle();
    reset = 1'b0;
  endtask

  logic [9:0] exp_m1_seq;
  int         j;

  initial begin
    // Reset state: requests are asserted but nothing may be granted.
    reset = 1'b1;
    drive0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    drive1(1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    sample();
    check("rst_m0_gnt",    m0_gnt,    0);
    check("rst_m1_gnt",    m1_gnt,    0);
    check("rst_mem_en",    mem_en,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rdata",  m1_rdata,  0);
    next_cycle();
    reset = 1'b0;
    idle();

    // 1: lone M0 read of 0x10 returns word 4 READ_LAT cycles later.
    drive0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    sample();
    check("t1_m0_gnt",   m0_gnt,   1);
    check("t1_m1_gnt",   m1_gnt,   0);
    check("t1_mem_en",   mem_en,   1);
    check("t1_mem_we",   mem_we,   0);
    check("t1_mem_addr", mem_addr, 32'h10);
    next_cycle();
    idle();
    sample();
    check("t1_early_rvalid", m0_rvalid, 0);
    check("t1_idle_mem_en",  mem_en,    0);
    next_cycle();
    sample();
    check("t1_m0_rvalid", m0_rvalid, 1);
    check("t1_m0_rdata",  m0_rdata,  32'hA000_0004);
    check("t1_m1_rvalid", m1_rvalid, 0);
    next_cycle();
    sample();
    check("t1_rvalid_drop", m0_rvalid, 0);
    check("t1_rdata_hold",  m0_rdata,  32'hA000_0004);

    // 2: both masters read every cycle; grants alternate starting with M0.
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        drive0(1'b1, 1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 32'h200 + 32'(4 * i), 32'h0);
      end else begin
        idle();
      end
      sample();
      check($sformatf("t2_m0_gnt_%0d", i), m0_gnt, (i < 6 && i % 2 == 0) ? 1 : 0);
      check($sformatf("t2_m1_gnt_%0d", i), m1_gnt, (i < 6 && i % 2 == 1) ? 1 : 0);
      j = i - READ_LAT;
      if (j >= 0 && j < 6) begin
        check($sformatf("t2_m0_rvalid_%0d", i), m0_rvalid, (j % 2 == 0) ? 1 : 0);
        check($sformatf("t2_m1_rvalid_%0d", i), m1_rvalid, (j % 2 == 1) ? 1 : 0);
        if (j % 2 == 0)
          check($sformatf("t2_m0_rdata_%0d", i), m0_rdata, 32'hA000_0040 + 32'(j));
        else
          check($sformatf("t2_m1_rdata_%0d", i), m1_rdata, 32'hA000_0080 + 32'(j));
      end else begin
        check($sformatf("t2_no_rvalid_%0d", i), {m0_rvalid, m1_rvalid}, 0);
      end
      next_cycle();
    end

    // 3: M1 holds a locked write burst for 3 cycles, then M0 reads it back.
    apply_reset();
    drive0(1'b1, 1'b1, 1'b0, 32'h30, 32'h55);
    sample();
    check("t3_pre_m0_gnt", m0_gnt, 1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive1(1'b1, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
      drive0(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
      sample();
      check($sformatf("t3_m1_gnt_%0d", i), m1_gnt, 1);
      check($sformatf("t3_m0_gnt_%0d", i), m0_gnt, 0);
      check($sformatf("t3_mem_we_%0d", i), mem_we, 1);
      check($sformatf("t3_wdata_%0d", i),  mem_wdata, 32'hDEAD_BEEF);
      next_cycle();
    end
    drive1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("t3_m0_gnt_after", m0_gnt, 1);
    check("t3_m1_gnt_after", m1_gnt, 0);
    next_cycle();
    idle();
    next_cycle();
    sample();
    check("t3_rd_rvalid", m0_rvalid, 1);
    check("t3_rd_rdata",  m0_rdata,  32'hDEAD_BEEF);

    // 4: M0 lock is broken after MAX_LOCK grants, M1 gets one, M0 re-locks.
    apply_reset();
    exp_m1_seq = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      drive0(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
      drive1(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      sample();
      check($sformatf("t4_m0_gnt_%0d", i), m0_gnt, !exp_m1_seq[i]);
      check($sformatf("t4_m1_gnt_%0d", i), m1_gnt, exp_m1_seq[i]);
      next_cycle();
    end
    idle();
    repeat (2) next_cycle();

    // 5: reset one cycle after the second grant discards both responses.
    apply_reset();
    drive0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    sample();
    check("t5_m0_gnt", m0_gnt, 1);
    next_cycle();
    idle();
    drive1(1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    sample();
    check("t5_m1_gnt", m1_gnt, 1);
    next_cycle();
    reset = 1'b1;
    drive0(1'b1, 1'b1, 1'b0, 32'h44, 32'h1234);
    drive1(1'b1, 1'b0, 1'b0, 32'h48, 32'h0);
    for (int i = 0; i < 2; i++) begin
      sample();
      check($sformatf("t5_rst_gnt_%0d", i),    {m0_gnt, m1_gnt}, 0);
      check($sformatf("t5_rst_mem_%0d", i),    {mem_en, mem_we}, 0);
      check($sformatf("t5_rst_addr_%0d", i),   mem_addr,  0);
      check($sformatf("t5_rst_wdata_%0d", i),  mem_wdata, 0);
      check($sformatf("t5_rst_rvalid_%0d", i), {m0_rvalid, m1_rvalid}, 0);
      check($sformatf("t5_rst_rdata0_%0d", i), m0_rdata, 0);
      check($sformatf("t5_rst_rdata1_%0d", i), m1_rdata, 0);
      next_cycle();
    end
    reset = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("t5_post_rvalid_%0d", i), {m0_rvalid, m1_rvalid}, 0);
      next_cycle();
    end

    // 6: M0 write beats M1 read (M1 last winner after reset); M1 follows.
    apply_reset();
    drive0(1'b1, 1'b1, 1'b0, 32'h40, 32'h1234_5678);
    drive1(1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    sample();
    check("t6_m0_gnt",   m0_gnt,   1);
    check("t6_m1_gnt",   m1_gnt,   0);
    check("t6_mem_we",   mem_we,   1);
    check("t6_mem_addr", mem_addr, 32'h40);
    next_cycle();
    drive0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("t6_m1_gnt2",   m1_gnt,   1);
    check("t6_mem_we2",   mem_we,   0);
    check("t6_mem_addr2", mem_addr, 32'h8);
    next_cycle();
    idle();
    sample();
    check("t6_early_rvalid", m1_rvalid, 0);
    next_cycle();
    sample();
    check("t6_m1_rvalid", m1_rvalid, 1);
    check("t6_m1_rdata",  m1_rdata,  32'hA000_0002);
    check("t6_m0_rvalid", m0_rvalid, 0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
